// File: rtl/rr_mux4_stage_if.sv
// Valid/ready bundle for the four-channel round-robin mux stage.
// The slave modport is the stage's view; master is the producer/consumer side.
interface rr_mux4_stage_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       v;
  logic [3:0]       rdy;
  logic [WIDTH-1:0] y;
  logic [1:0]       s;
  logic             y_valid;
  logic             y_ready;

  modport slave (
    input  d0, d1, d2, d3, v, y_ready,
    output rdy, y, s, y_valid
  );

  modport master (
    output d0, d1, d2, d3, v, y_ready,
    input  rdy, y, s, y_valid
  );
endinterface

// File: rtl/rr_mux4_stage.sv
// Round-robin arbiter over four valid/ready channels feeding a one-word
// registered output stage that carries the winning channel index in s.
module rr_mux4_stage #(
  parameter int WIDTH = 12
) (
  input logic            clk,
  input logic            reset,
  rr_mux4_stage_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [1:0]       grant;
  logic             any_req;
  logic             load;
  logic [WIDTH-1:0] grant_data;

  assign any_req = |bus.v;
  assign load    = ((state_q == EMPTY) || bus.y_ready) && any_req;

  // First requesting channel scanning upward from ptr, wrapping mod 4.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a variable unassigned and infer a latch.
  always_comb begin
    logic found;
    grant = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && bus.v[ptr_q + 2'(k)]) begin
        grant = ptr_q + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    grant_data = bus.d0;
      2'd1:    grant_data = bus.d1;
      2'd2:    grant_data = bus.d2;
      default: grant_data = bus.d3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    y_d     = y_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (bus.y_ready && !any_req) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load) begin
      y_d   = grant_data;
      s_d   = grant;
      ptr_d = grant + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= 2'd0;
      s_q     <= 2'd0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      y_q     <= y_d;
    end
  end

  // rdy is gated by reset directly: with y_valid cleared, load alone would
  // still grant a requester while reset is held.
  assign bus.rdy     = (load && !reset) ? (4'b0001 << grant) : 4'b0000;
  assign bus.y       = y_q;
  assign bus.s       = s_q;
  assign bus.y_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux4_stage.sv
// Directed bench for rr_mux4_stage: reset, drain order, back-pressure,
// wrap-around, single requester, idle drain and mid-stream reset.
module tb_rr_mux4_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_mux4_stage_if #(.WIDTH(12)) bus ();

  rr_mux4_stage #(.WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [11:0] ey, input logic [1:0] es,
                           input logic ev);
    check({tag, ".y"}, 32'(bus.y), 32'(ey));
    check({tag, ".s"}, 32'(bus.s), 32'(es));
    check({tag, ".y_valid"}, 32'(bus.y_valid), 32'(ev));
  endtask

  logic [11:0] drain_y   [5] = '{12'h000, 12'h555, 12'hAAA, 12'hFFF, 12'h000};
  logic [1:0]  drain_s   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0]  drain_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    reset       = 1'b1;
    bus.d0      = 12'h000;
    bus.d1      = 12'h555;
    bus.d2      = 12'hAAA;
    bus.d3      = 12'hFFF;
    bus.v       = 4'b1111;
    bus.y_ready = 1'b1;
    #2;
    check_out("reset", 12'h000, 2'd0, 1'b0);
    check("reset.rdy", 32'(bus.rdy), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // All four requesting: grants rotate 0,1,2,3,0
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d.rdy", i), 32'(bus.rdy), 32'(drain_rdy[i]));
      tick();
      check_out($sformatf("drain%0d", i), drain_y[i], drain_s[i], 1'b1);
    end
    check("pre_bp.rdy", 32'(bus.rdy), 32'b0010);
    tick();
    check_out("pre_bp", 12'h555, 2'd1, 1'b1);

    // Back-pressure: output frozen, no grants
    bus.y_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d.rdy", i), 32'(bus.rdy), 32'h0);
      tick();
      check_out($sformatf("bp%0d", i), 12'h555, 2'd1, 1'b1);
    end
    bus.y_ready = 1'b1;
    #1;
    check("bp_rel.rdy", 32'(bus.rdy), 32'b0100);
    tick();
    check_out("bp_rel", 12'hAAA, 2'd2, 1'b1);

    // Wrap-around past channel 3
    check("wrap_a.rdy", 32'(bus.rdy), 32'b1000);
    tick();
    check_out("wrap_a", 12'hFFF, 2'd3, 1'b1);
    bus.v = 4'b1001;
    #1;
    check("wrap_b.rdy", 32'(bus.rdy), 32'b0001);
    tick();
    check_out("wrap_b", 12'h000, 2'd0, 1'b1);
    check("wrap_c.rdy", 32'(bus.rdy), 32'b1000);
    tick();
    check_out("wrap_c", 12'hFFF, 2'd3, 1'b1);

    // Single requester granted every cycle
    bus.d2 = 12'h5A5;
    bus.v  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("single%0d.rdy", i), 32'(bus.rdy), 32'b0100);
      tick();
      check_out($sformatf("single%0d", i), 12'h5A5, 2'd2, 1'b1);
    end

    // Idle drain: word consumed, ptr left at 3
    bus.v = 4'b0000;
    #1;
    check("idle.rdy", 32'(bus.rdy), 32'h0);
    tick();
    check_out("idle", 12'h5A5, 2'd2, 1'b0);
    bus.v = 4'b1111;
    #1;
    check("idle_ptr.rdy", 32'(bus.rdy), 32'b1000);
    tick();
    check_out("idle_ptr", 12'hFFF, 2'd3, 1'b1);

    // Mid-stream reset clears outputs before any edge
    bus.d2 = 12'hAAA;
    bus.v  = 4'b0100;
    #1;
    tick();
    check_out("pre_rst", 12'hAAA, 2'd2, 1'b1);
    bus.v = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    check_out("mid_rst", 12'h000, 2'd0, 1'b0);
    check("mid_rst.rdy", 32'(bus.rdy), 32'h0);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst.rdy", 32'(bus.rdy), 32'b0001);
    tick();
    check_out("post_rst", 12'h000, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
